// File: rtl/fp32_uart_pkg.sv
// Shared constants and types for the FP32 UART link (TX and RX sides).
package fp32_uart_pkg;

  localparam int CLKS_PER_BIT = 5208;
  localparam int NUM_BYTES    = 12;

  // state | meaning
  // IDLE  | line high, ready for a word
  // START | driving start bit (0)
  // DATA  | driving d0..d7, LSB first
  // STOP  | driving stop bit (1)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/fp32_uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module fp32_uart_baud_cnt #(
  parameter int CLKS_PER_BIT = fp32_uart_pkg::CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_cnt;

  assign last_cnt   = (cnt_q == LAST_CNT);
  assign bit_tick_o = en_i & last_cnt;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fp32_uart_tx.sv
// FP32 link transmitter: latches one NUM_BYTES-byte word and sends it as back-to-back
// 8N1 frames, byte 0 first, LSB first within each byte.
module fp32_uart_tx
  import fp32_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = fp32_uart_pkg::CLKS_PER_BIT,
  parameter int NUM_BYTES    = fp32_uart_pkg::NUM_BYTES
) (
  input  logic                   CLK_I,
  input  logic                   RSTL_I,
  input  logic                   TX_VALID_I,
  output logic                   TX_READY_O,
  input  logic [NUM_BYTES*8-1:0] TX_DATA_I,
  output logic                   UART_TX_O,
  output logic                   TX_DONE_O
);

  localparam int DW = NUM_BYTES * 8;
  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

  tx_state_t       state_q, state_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [BW-1:0]   byte_idx_q, byte_idx_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            accept;
  logic            bit_tick;
  logic            cnt_en;

  assign cnt_en = (state_q != IDLE);

  fp32_uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk_i     (CLK_I),
    .rst_n_i   (RSTL_I),
    .clr_i     (accept),
    .en_i      (cnt_en),
    .bit_tick_o(bit_tick)
  );

  // tx_d is the value the line takes in the cycle after this edge, so every
  // bit boundary is decided one cycle early and the line stays registered.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    accept     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (TX_VALID_I && ready_q) begin
          accept     = 1'b1;
          state_d    = START;
          tx_d       = 1'b0;
          shreg_d    = TX_DATA_I;
          bit_idx_d  = '0;
          byte_idx_d = '0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d    = START;
            tx_d       = 1'b0;
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign ready_d = (state_d == IDLE);

  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign UART_TX_O  = tx_q;
  assign TX_READY_O = ready_q;
  assign TX_DONE_O  = done_q;

endmodule

// File: tb/tb_fp32_uart_tx.sv
// Self-checking bench for fp32_uart_tx against a frame-level model of the serial line.
module tb_fp32_uart_tx;

  localparam int CPB      = 16;
  localparam int NB       = 12;
  localparam int FRAME    = 10 * CPB;
  localparam int WORD_CYC = NB * FRAME;

  logic          CLK_I      = 1'b0;
  logic          RSTL_I     = 1'b0;
  logic          TX_VALID_I = 1'b0;
  logic [95:0]   TX_DATA_I  = '0;
  logic          TX_READY_O;
  logic          UART_TX_O;
  logic          TX_DONE_O;

  int n_checks = 0;
  int n_errors = 0;

  fp32_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES   (NB)
  ) dut (
    .CLK_I     (CLK_I),
    .RSTL_I    (RSTL_I),
    .TX_VALID_I(TX_VALID_I),
    .TX_READY_O(TX_READY_O),
    .TX_DATA_I (TX_DATA_I),
    .UART_TX_O (UART_TX_O),
    .TX_DONE_O (TX_DONE_O)
  );

  always #5 CLK_I = ~CLK_I;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [95:0] word;
    logic [7:0]  b0;
    logic [7:0]  b11;
  } vec_t;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected line level i cycles after the first start-bit cycle of word w.
  function automatic logic model_line(input logic [95:0] w, input int i);
    int         k;
    int         j;
    logic [7:0] b;
    k = i / FRAME;
    j = (i % FRAME) / CPB;
    b = 8'((w >> (8 * k)) & 96'hFF);
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return b[j-1];
  endfunction

  // Entered at the falling edge of the first start-bit cycle; returns at the
  // falling edge of the cycle in which TX_DONE_O should be high.
  task automatic watch_word(input string tag, input logic [95:0] w, input logic [95:0] busy_data,
                            input bit keep_valid, output logic [95:0] dec);
    logic s;
    logic samp [WORD_CYC];
    int   wave_err    = 0;
    int   early_done  = 0;
    int   early_ready = 0;
    int   ferr        = 0;
    chk_b($sformatf("%s start_bit_latency", tag), UART_TX_O, 1'b0);
    chk_b($sformatf("%s ready_low_after_accept", tag), TX_READY_O, 1'b0);
    TX_DATA_I = busy_data;
    for (int i = 0; i < WORD_CYC; i++) begin
      if (i > 0) @(negedge CLK_I);
      samp[i] = UART_TX_O;
      if (UART_TX_O !== model_line(w, i)) wave_err++;
      if (TX_DONE_O !== 1'b0) early_done++;
      if (TX_READY_O !== 1'b0) early_ready++;
      if (!keep_valid && i == WORD_CYC / 2) TX_VALID_I = 1'b0;
    end
    chk_i($sformatf("%s waveform_mismatch_cycles", tag), wave_err, 0);
    chk_i($sformatf("%s done_during_word", tag), early_done, 0);
    chk_i($sformatf("%s ready_during_word", tag), early_ready, 0);
    @(negedge CLK_I);
    chk_b($sformatf("%s done_pulse", tag), TX_DONE_O, 1'b1);
    chk_b($sformatf("%s ready_after_word", tag), TX_READY_O, 1'b1);
    chk_b($sformatf("%s line_idle_after_word", tag), UART_TX_O, 1'b1);
    dec = '0;
    for (int k = 0; k < NB; k++) begin
      for (int j = 0; j < 10; j++) begin
        s = samp[k * FRAME + j * CPB + CPB / 2];
        if (j == 0) begin
          if (s !== 1'b0) ferr++;
        end else if (j == 9) begin
          if (s !== 1'b1) ferr++;
        end else begin
          dec[k * 8 + j - 1] = s;
        end
      end
    end
    chk_i($sformatf("%s framing_errors", tag), ferr, 0);
    chk($sformatf("%s decoded_word", tag), dec, w);
  endtask

  task automatic send_word(input string tag, input logic [95:0] w, input logic [95:0] busy_data,
                           input bit keep_valid, output logic [95:0] dec);
    @(negedge CLK_I);
    chk_b($sformatf("%s ready_before", tag), TX_READY_O, 1'b1);
    chk_b($sformatf("%s line_idle_before", tag), UART_TX_O, 1'b1);
    TX_VALID_I = 1'b1;
    TX_DATA_I  = w;
    @(negedge CLK_I);
    watch_word(tag, w, busy_data, keep_valid, dec);
  endtask

  initial begin
    vec_t        vecs[4];
    logic [7:0]  pi_bytes[12];
    logic [95:0] dec;
    logic [95:0] w1;
    logic [95:0] w2;
    int          bad_line;
    int          bad_ready;
    int          bad_done;
    int          off;

    vecs[0] = '{"pi_vec",   96'h4049_0FDB_3F80_0000_C000_0000, 8'h00, 8'h40};
    vecs[1] = '{"all_ones", {96{1'b1}},                        8'hFF, 8'hFF};
    vecs[2] = '{"all_zero", 96'h0,                             8'h00, 8'h00};
    vecs[3] = '{"ramp",     96'h0123_4567_89AB_CDEF_FEDC_BA98, 8'h98, 8'h01};
    pi_bytes = '{8'h00, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h00,
                 8'h80, 8'h3F, 8'hDB, 8'h0F, 8'h49, 8'h40};

    // Reset and a long idle stretch
    repeat (3) @(negedge CLK_I);
    chk_b("reset line", UART_TX_O, 1'b1);
    chk_b("reset ready", TX_READY_O, 1'b1);
    chk_b("reset done", TX_DONE_O, 1'b0);
    RSTL_I = 1'b1;
    bad_line = 0; bad_ready = 0; bad_done = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK_I);
      if (UART_TX_O !== 1'b1) bad_line++;
      if (TX_READY_O !== 1'b1) bad_ready++;
      if (TX_DONE_O !== 1'b0) bad_done++;
    end
    chk_i("idle line_not_high_cycles", bad_line, 0);
    chk_i("idle ready_not_high_cycles", bad_ready, 0);
    chk_i("idle done_high_cycles", bad_done, 0);

    // Directed vectors
    for (int v = 0; v < 4; v++) begin
      send_word(vecs[v].name, vecs[v].word, vecs[v].word, 1'b0, dec);
      chk_i($sformatf("%s first_byte", vecs[v].name), int'(dec[7:0]), int'(vecs[v].b0));
      chk_i($sformatf("%s last_byte", vecs[v].name), int'(dec[95:88]), int'(vecs[v].b11));
      if (v == 0) begin
        for (int k = 0; k < 12; k++)
          chk_i($sformatf("pi_vec byte%0d", k), int'(dec[k*8 +: 8]), int'(pi_bytes[k]));
      end
      @(negedge CLK_I);
      chk_b($sformatf("%s done_single_cycle", vecs[v].name), TX_DONE_O, 1'b0);
      chk_b($sformatf("%s no_restart", vecs[v].name), UART_TX_O, 1'b1);
    end

    // Different data offered while busy must be ignored
    send_word("busy_ignore", 96'hA5A5_5A5A_0F0F_F0F0_1234_5678,
              96'h0000_1111_2222_3333_4444_5555, 1'b0, dec);
    @(negedge CLK_I);
    chk_b("busy_ignore no_second_word", UART_TX_O, 1'b1);

    // Back-to-back words with VALID held high across the boundary
    w1 = {$urandom, $urandom, $urandom};
    w2 = {$urandom, $urandom, $urandom};
    send_word("b2b_first", w1, w2, 1'b1, dec);
    @(negedge CLK_I);
    watch_word("b2b_second", w2, w2, 1'b0, dec);
    @(negedge CLK_I);

    // Random words with random idle gaps
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 20)) @(negedge CLK_I);
      w1 = {$urandom, $urandom, $urandom};
      send_word($sformatf("rand%0d", r), w1, ~w1, 1'b0, dec);
    end

    // Reset during byte 5, data bit 3
    w1 = 96'h1111_1111_1111_0011_1111_1111;
    @(negedge CLK_I);
    TX_VALID_I = 1'b1;
    TX_DATA_I  = w1;
    @(negedge CLK_I);
    TX_VALID_I = 1'b0;
    off = 5 * FRAME + 4 * CPB + 6;
    repeat (off) @(negedge CLK_I);
    chk_b("midreset line_before", UART_TX_O, model_line(w1, off));
    chk_b("midreset busy_before", TX_READY_O, 1'b0);
    #2;
    RSTL_I = 1'b0;
    #1;
    chk_b("midreset line_async", UART_TX_O, 1'b1);
    chk_b("midreset ready_async", TX_READY_O, 1'b1);
    chk_b("midreset done_async", TX_DONE_O, 1'b0);
    repeat (3) @(negedge CLK_I);
    RSTL_I = 1'b1;
    @(negedge CLK_I);
    chk_b("midreset ready_after_release", TX_READY_O, 1'b1);
    chk_b("midreset line_after_release", UART_TX_O, 1'b1);
    send_word("post_reset", 96'hDEAD_BEEF_CAFE_F00D_8BAD_F00D, 96'hDEAD_BEEF_CAFE_F00D_8BAD_F00D,
              1'b0, dec);
    chk_i("post_reset first_byte", int'(dec[7:0]), 32'h0D);

    repeat (5) @(negedge CLK_I);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
